pipe_stage_skid: RTL and testbench

//  Parametrised elastic pipeline stage register: successor to the fixed, always-enabled stage registers.

---
 rtl/pipe_stage_skid_if.sv | 12 +
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 tb/tb_pipe_stage_skid.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake bundle for one side of an elastic pipeline stage.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer; every output is decoded from registers.
// Defining PIPE_STAGE_PERF_EN adds saturating stall/bubble counters and their ports.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    pipe_stage_skid_if.slave        in_if,
    pipe_stage_skid_if.master       out_if,
    output logic [1:0]              occupancy_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    assign in_if.ready  = (state_q != StFull);
    assign out_if.valid = (state_q != StEmpty);
    assign out_if.data  = main_q;
    assign occupancy_o  = state_q;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_fire  = in_if.valid & in_if.ready;
        out_fire = out_if.valid & out_if.ready;
        // Flush beats every transition; payload registers keep stale data while empty.
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_if.data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_if.data;
                    end else if (in_fire) begin
                        skid_d  = in_if.data;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    // Saturate rather than wrap; only reset clears these.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_if.valid && !out_if.ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (!out_if.valid && out_if.ready && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a 2-deep FIFO model predicts each cycle and a
// negedge monitor compares. Build with PIPE_STAGE_PERF_EN to also check the counters.
module tb_pipe_stage_skid;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    typedef struct {
        int            occ;
        logic [DW-1:0] head;
        int            stall;
        int            bubble;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_skid_if #(.DATA_W(DW)) in_if ();
    pipe_stage_skid_if #(.DATA_W(DW)) out_if ();

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .in_if(in_if), .out_if(out_if),
        .occupancy_o(occupancy), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
    );
`else
    pipe_stage_skid #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .in_if(in_if), .out_if(out_if),
        .occupancy_o(occupancy)
    );
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    exp_t          cyc_q[$];
    int            stall_m = 0;
    int            bubble_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; the model advances using only its own FIFO contents.
    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        exp_t e;
        bit   ofire, ifire;
        @(posedge clk);
        #2;
        in_if.valid  = iv;
        in_if.data   = d;
        out_if.ready = ordy;
        flush        = fl;
        e.occ    = model.size();
        e.head   = (model.size() > 0) ? model[0] : '0;
        e.stall  = stall_m;
        e.bubble = bubble_m;
        cyc_q.push_back(e);
        ofire = ordy && (model.size() > 0);
        ifire = iv && (model.size() < 2);
        if (model.size() > 0 && !ordy && stall_m < CMAX) stall_m++;
        if (model.size() == 0 && ordy && bubble_m < CMAX) bubble_m++;
        if (ofire) exp_q.push_back(model.pop_front());
        if (fl) model.delete();
        else if (ifire) model.push_back(d);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #6;
        reset = 1'b0;
        in_if.valid = 1'b0;
        flush = 1'b0;
        #1;
        chk({tag, "_out_valid"}, 64'(out_if.valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_if.data), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_if.ready), 64'd1);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
        chk({tag, "_bubble_cnt"}, 64'(bubble_cnt), 64'd0);
`endif
        model.delete();
        stall_m  = 0;
        bubble_m = 0;
        repeat (2) @(posedge clk);
        #6;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            exp_t e;
            e = cyc_q.pop_front();
            chk("occupancy", 64'(occupancy), 64'(e.occ));
            chk("out_valid", 64'(out_if.valid), 64'(e.occ != 0));
            chk("in_ready", 64'(in_if.ready), 64'(e.occ != 2));
            if (e.occ != 0) chk("out_data_head", 64'(out_if.data), 64'(e.head));
`ifdef PIPE_STAGE_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bubble));
`endif
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_if.data);
                end else begin
                    chk("out_fire_data", 64'(out_if.data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        do_reset("rst0");

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: 0xA, 0xB fill the stage, 0xC waits, then drain.
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        repeat (3) step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Flush while full with a same-cycle 0xD.
        step(1'b1, 32'h1A, 1'b0, 1'b0);
        step(1'b1, 32'h1B, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous in/out fire at occupancy 1.
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Long stall to saturate stall_cnt, then flush must leave it alone.
        step(1'b1, 32'h77, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
        do_reset("rst_perf");
`endif

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        // Reset mid-stream with the stage full.
        step(1'b1, 32'h31, 1'b0, 1'b0);
        step(1'b1, 32'h32, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        do_reset("rst_mid");
        for (int i = 0; i < 6; i++) step(1'b1, DW'(32'h40 + i), 1'b1, 1'b0);

        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size() + cyc_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
